// File: rtl/round_pkg.sv
// round_pkg: shared definitions for the round-counter sequencer.
//   - default block width, round count and counter width
//   - sequencer state encoding
package round_pkg;

    localparam int unsigned DATA_W_DEF = 128;
    localparam int unsigned ROUNDS_DEF = 17;
    localparam int unsigned CNT_W_DEF  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StClear
    } round_state_e;

endpackage

// File: rtl/round_watchdog.sv
// round_watchdog: counts consecutive cycles with en high and flags the cycle
// in which the count reaches limit.
// Ports:
//   clk     system clock
//   rst     synchronous active-high reset
//   en      count enable (sequencer in RUN); clearing happens whenever en is low
//   limit   number of enabled cycles allowed
//   expired high during the limit-th consecutive enabled cycle
module round_watchdog #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;

    // count_q holds the number of enabled cycles already completed.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + W'(1);
        end
    end

    assign expired = en && (count_q == (limit - W'(1)));

endmodule

// File: rtl/round_ctrl.sv
// round_ctrl: initiator-side sequencer for the block-cipher round counter.
// Accepts one block, holds start to the external counter while one round per
// count value is applied, presents the result, then drops start for one cycle
// so the counter clears before the next job.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready/in_data     upstream block handshake
//   start                  registered request to the round counter
//   cnt, cnt_end           counter value and terminal flag
//   round_en, round_idx    apply-round strobe and round number (= cnt)
//   dp_state, dp_next      state to / result from the round function
//   out_valid/out_ready/out_data  downstream result handshake
//   err                    sticky watchdog fault, cleared only by rst
module round_ctrl
    import round_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ROUNDS = ROUNDS_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned WDOG   = ROUNDS + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              start,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              cnt_end,
    output logic              round_en,
    output logic [CNT_W-1:0]  round_idx,
    output logic [DATA_W-1:0] dp_state,
    input  logic [DATA_W-1:0] dp_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    localparam int unsigned WD_W = $clog2(WDOG + 1);

    round_state_e      state_q, state_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    // High for the first cycle after reset: start has only just dropped, so the
    // counter may still show a stale non-zero value with cnt_end low.
    logic              fresh_q;
    logic              run_en;
    logic              wd_expired;

    assign run_en = (state_q == StRun);

    round_watchdog #(
        .W(WD_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (run_en),
        .limit  (WD_W'(WDOG)),
        .expired(wd_expired)
    );

    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        data_d    = data_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        round_en  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = ~cnt_end & ~fresh_q;
                if (in_valid && in_ready) begin
                    data_d  = in_data;
                    start_d = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                start_d  = 1'b1;
                round_en = ~cnt_end & (cnt < CNT_W'(ROUNDS));
                if (round_en) begin
                    data_d = dp_next;
                end
                // A terminal count wins over a watchdog expiry in the same cycle.
                if (cnt_end) begin
                    state_d = StDone;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    start_d = 1'b0;
                    state_d = StClear;
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    start_d = 1'b0;
                    state_d = StClear;
                end
            end
            StClear: begin
                start_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                start_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            start_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            fresh_q <= 1'b1;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            data_q  <= data_d;
            err_q   <= err_d;
            fresh_q <= 1'b0;
        end
    end

    assign start     = start_q;
    assign round_idx = cnt;
    assign dp_state  = data_q;
    assign out_data  = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: directed self-checking bench for round_ctrl with a behavioural
// round counter and the dummy round function dp_next = dp_state + round_idx + 1.
module tb_round_ctrl;

    localparam int DW = 128;
    localparam int R  = 17;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          start;
    logic [CW-1:0] cnt;
    logic          cnt_end;
    logic          round_en;
    logic [CW-1:0] round_idx;
    logic [DW-1:0] dp_state;
    logic [DW-1:0] dp_next;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    round_ctrl u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .start    (start),
        .cnt      (cnt),
        .cnt_end  (cnt_end),
        .round_en (round_en),
        .round_idx(round_idx),
        .dp_state (dp_state),
        .dp_next  (dp_next),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err      (err)
    );

    // Round counter model: clears while start is low, counts to R and holds.
    logic [CW-1:0] cnt_q = '0;
    logic          end_q = 1'b0;
    logic          stuck = 1'b0;
    logic          hold_end = 1'b0;

    always @(posedge clk) begin
        if (!start) begin
            cnt_q <= '0;
            end_q <= 1'b0;
        end else if (!end_q) begin
            cnt_q <= cnt_q + CW'(1);
            end_q <= (cnt_q == CW'(R - 1));
        end
    end

    assign cnt     = cnt_q;
    assign cnt_end = (end_q & ~stuck) | hold_end;
    assign dp_next = dp_state + DW'(round_idx) + DW'(1);

    // Monitors
    int            cyc = 0;
    int            ren_cnt = 0;
    int            ov_cnt = 0;
    int            acc_q[$];
    logic [DW-1:0] res_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (round_en) ren_cnt <= ren_cnt + 1;
        if (out_valid) ov_cnt <= ov_cnt + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) res_q.push_back(out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block, then count cycles from the accept edge to out_valid.
    task automatic send(input logic [DW-1:0] d, output int lat);
        in_data  = d;
        in_valid = 1'b1;
        lat      = 0;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        if (!in_ready) begin
            in_valid = 1'b0;
            lat      = -1;
            return;
        end
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (round_en !== 1'b0) begin n_err++; $display("FAIL reset_round_en: got %b want 0", round_en); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
        n_vec++; if (dp_state !== '0) begin n_err++; $display("FAIL reset_state: got %0h want 0", dp_state); end
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_single();
        int lat;
        int r0;
        r0 = ren_cnt;
        send('0, lat);
        n_vec++; if (lat !== 18) begin n_err++; $display("FAIL single_latency: got %0d want 18", lat); end
        n_vec++; if (out_data !== DW'(153)) begin n_err++; $display("FAIL single_data: got %0d want 153", out_data); end
        n_vec++; if (ren_cnt - r0 !== 17) begin n_err++; $display("FAIL single_rounds: got %0d want 17", ren_cnt - r0); end
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL single_done_start: got %b want 1", start); end
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_clear_valid: got %b want 0", out_valid); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL single_clear_start: got %b want 0", start); end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int a0;
        int r0;
        a0 = acc_q.size();
        r0 = res_q.size();
        out_ready = 1'b1;
        in_data   = '0;
        in_valid  = 1'b1;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (acc_q.size() == a0 + 1) in_data = DW'(5);
            if (acc_q.size() >= a0 + 2) in_valid = 1'b0;
            if (res_q.size() >= r0 + 2) break;
        end
        in_valid = 1'b0;
        n_vec++;
        if (acc_q.size() < a0 + 2) begin
            n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc_q.size() - a0);
        end else if (acc_q[a0 + 1] - acc_q[a0] !== 21) begin
            n_err++; $display("FAIL b2b_spacing: got %0d want 21", acc_q[a0 + 1] - acc_q[a0]);
        end
        n_vec++;
        if (res_q.size() < r0 + 2) begin
            n_err++; $display("FAIL b2b_results: got %0d want 2", res_q.size() - r0);
        end else begin
            if (res_q[r0] !== DW'(153)) begin
                n_err++; $display("FAIL b2b_data0: got %0d want 153", res_q[r0]);
            end
            n_vec++;
            if (res_q[r0 + 1] !== DW'(158)) begin
                n_err++; $display("FAIL b2b_data1: got %0d want 158", res_q[r0 + 1]);
            end
        end
        out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        int r0;
        out_ready = 1'b0;
        r0 = ren_cnt;
        send(DW'(1), lat);
        n_vec++; if (lat !== 18) begin n_err++; $display("FAIL bp_latency: got %0d want 18", lat); end
        in_valid = 1'b1;
        in_data  = DW'(9);
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
            n_vec++; if (out_data !== DW'(154)) begin n_err++; $display("FAIL bp_data[%0d]: got %0d want 154", i, out_data); end
            n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL bp_start[%0d]: got %b want 1", i, start); end
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        n_vec++; if (ren_cnt - r0 !== 17) begin n_err++; $display("FAIL bp_rounds: got %0d want 17", ren_cnt - r0); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got %b want 0", out_valid); end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        int n;
        int o0;
        int lat;
        stuck    = 1'b1;
        o0       = ov_cnt;
        in_data  = DW'(3);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!err && n < 60) begin
            tick();
            n++;
        end
        n_vec++; if (n !== 20) begin n_err++; $display("FAIL wdog_cycles: got %0d want 20", n); end
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL wdog_start: got %b want 0", start); end
        stuck = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wdog_idle: got %b want 1", in_ready); end
        n_vec++; if (ov_cnt !== o0) begin n_err++; $display("FAIL wdog_no_valid: got %0d want %0d", ov_cnt, o0); end
        send('0, lat);
        n_vec++; if (lat !== 18) begin n_err++; $display("FAIL wdog_next_latency: got %0d want 18", lat); end
        n_vec++; if (out_data !== DW'(153)) begin n_err++; $display("FAIL wdog_next_data: got %0d want 153", out_data); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL wdog_sticky: got %b want 1", err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_run();
        int n;
        int o0;
        int lat;
        in_data  = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) tick();
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!(round_en && round_idx == CW'(7)) && n < 40) begin
            tick();
            n++;
        end
        n_vec++; if (n !== 7) begin n_err++; $display("FAIL mid_round7: got %0d want 7", n); end
        rst = 1'b1;
        tick();
        n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL mid_start: got %b want 0", start); end
        n_vec++; if (round_en !== 1'b0) begin n_err++; $display("FAIL mid_round_en: got %b want 0", round_en); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mid_err_clr: got %b want 0", err); end
        n_vec++; if (dp_state !== '0) begin n_err++; $display("FAIL mid_state: got %0h want 0", dp_state); end
        rst = 1'b0;
        o0  = ov_cnt;
        tick();
        tick();
        tick();
        n_vec++; if (ov_cnt !== o0) begin n_err++; $display("FAIL mid_no_valid: got %0d want %0d", ov_cnt, o0); end
        send(DW'(2), lat);
        n_vec++; if (lat !== 18) begin n_err++; $display("FAIL mid_next_latency: got %0d want 18", lat); end
        n_vec++; if (out_data !== DW'(155)) begin n_err++; $display("FAIL mid_next_data: got %0d want 155", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_post_reset_end();
        int lat;
        hold_end = 1'b1;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_data  = DW'(4);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL pre_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_vec++; if (start !== 1'b0) begin n_err++; $display("FAIL pre_start[%0d]: got %b want 0", i, start); end
        end
        hold_end = 1'b0;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL pre_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_vec++; if (start !== 1'b1) begin n_err++; $display("FAIL pre_accept: got %b want 1", start); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        n_vec++; if (lat !== 18) begin n_err++; $display("FAIL pre_latency: got %0d want 18", lat); end
        n_vec++; if (out_data !== DW'(157)) begin n_err++; $display("FAIL pre_data: got %0d want 157", out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_watchdog();
        test_reset_mid_run();
        test_post_reset_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
# round_ctrl

Initiator-side sequencer for the round counter in the block-cipher datapath. It accepts one input block over a valid/ready handshake and drives the counter's `start` request. While the counter runs, it applies one datapath round per count value and watches `cnt_end` to detect completion. It then presents the finished block downstream and releases `start` so the counter clears for the next job.

## Interface
Parameters:
- `DATA_W`, 128, width of the block state
- `ROUNDS`, 17, rounds per block; equals the counter's terminal count
- `CNT_W`, 5, width of `cnt`; must satisfy 2^CNT_W > ROUNDS
- `WDOG`, ROUNDS+3, cycles allowed in RUN before declaring a counter fault

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream block valid
- `in_ready`  out  1  upstream ready
- `in_data`  in  DATA_W  upstream block
- `start`  out  1  registered request to the round counter
- `cnt`  in  CNT_W  counter value
- `cnt_end`  in  1  counter terminal flag
- `round_en`  out  1  apply one round this cycle
- `round_idx`  out  CNT_W  round number for key/constant select; equals `cnt`
- `dp_state`  out  DATA_W  current block state to the round function
- `dp_next`  in  DATA_W  round-function result, combinational from `dp_state`/`round_idx`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream ready
- `out_data`  out  DATA_W  finished block; equals `dp_state`
- `err`  out  1  sticky watchdog fault

## Operation
- States: IDLE, RUN, DONE, CLEAR.
- IDLE:
  - `in_ready = ~cnt_end`. This blocks acceptance until the counter has cleared.
  - On `in_valid & in_ready`: state reg <= `in_data`, `start` <= 1, go to RUN.
- RUN:
  - `start` = 1.
  - `round_en = ~cnt_end & (cnt < ROUNDS)`.
  - When `round_en` is high, state reg <= `dp_next`.
  - When `cnt_end` = 1, go to DONE. The state reg is not updated in that cycle.
  - Watchdog counts RUN cycles. If it reaches `WDOG` without `cnt_end`: `err` <= 1, `start` <= 0, go to CLEAR. The block is discarded and `out_valid` never asserts for it.
- DONE:
  - `out_valid` = 1; `start` stays 1 so the counter holds.
  - `out_data` stays stable until `out_valid & out_ready`. Then `start` <= 0 and go to CLEAR.
- CLEAR:
  - Exactly one cycle, `start` = 0, so the counter returns to `cnt` = 0, `cnt_end` = 0.
  - Go to IDLE.
- `round_idx` = `cnt` always. `round_en` is 0 outside RUN.
- `err` is cleared only by `rst`. The block keeps operating after a fault.

## Timing
- Reset values:
  - state IDLE, `start` 0, `out_valid` 0, `round_en` 0, `err` 0, state reg 0.
  - `in_ready` follows `~cnt_end`. It may stay low for one cycle after reset while the counter clears.
- Accept edge E0: `start` is high from E0.
  - Rounds 0..ROUNDS-1 are applied on edges E1..E_ROUNDS.
  - `cnt_end` is seen after edge E_ROUNDS.
  - `out_valid` rises after edge E_(ROUNDS+1).
- Latency from accept to `out_valid` is ROUNDS+1 cycles (18 at defaults).
- With `out_ready` held high, back-to-back throughput is one block per ROUNDS+4 cycles:
  - 1 cycle DONE, 1 cycle CLEAR, 1 cycle IDLE, plus the ROUNDS+1 latency.
- `in_valid` held during RUN/DONE/CLEAR is not accepted (`in_ready` = 0). Upstream must hold `in_data` stable.
- `rst` mid-RUN or mid-DONE: the job is aborted, no `out_valid`, and `start` drops on that edge. The next accept cannot occur before the counter clears.
- `out_ready` low in DONE: hold everything indefinitely. The watchdog is inactive outside RUN.

## Structure
- Shared package `round_pkg` holds:
  - the state enum (IDLE, RUN, DONE, CLEAR)
  - the ROUNDS and CNT_W defaults
  - the DATA_W default
- One sub-module is natural: `round_watchdog`.
  - Ports: `clk`, `rst`, `en` (state==RUN), `limit`, `expired`.
  - Counter clears whenever `en` = 0.
- The round counter itself is instantiated by the parent, not inside this block.

## Test plan
- Single block: reset, then `in_data`=0x0 with a dummy round function `dp_next = dp_state + round_idx + 1`. Expect `out_data` = 153 (0x99) with `out_valid` exactly 18 cycles after accept.
- Back-to-back: two blocks with `in_valid` and `out_ready` held high. Expect accepts 21 cycles apart and both results correct.
- Backpressure: hold `out_ready` low for 10 cycles in DONE. Expect `out_data`/`out_valid` stable, `start` = 1, `in_ready` = 0, no extra `round_en`.
- Watchdog: counter model with `cnt_end` stuck at 0. Expect `err` = 1 after 20 RUN cycles, no `out_valid`, return to IDLE, and `err` still 1 after the next good block.
- Reset mid-RUN at round 7: expect `start` 0 and IDLE next cycle, no `out_valid`, and a following block producing the correct result.
- Post-reset `cnt_end` = 1 from the counter: expect `in_ready` = 0 until `cnt_end` falls, then normal accept.
